// File: rtl/cic_interpolator.sv
// cic_interpolator: 3-stage CIC interpolator with I/Q time-multiplexed over AXI-Stream (CIC_INTERP_CFG_EN adds a runtime rate port).
// Latency: first output I beat valid 2 cycles after the Q input handshake, then 2R beats (I then Q for each of R pairs).
// Backpressure: M_AXIS_tready low freezes output data and integrators; S_AXIS_tready is low while a burst is emitted.
module cic_interpolator #(
   parameter int RATE_DEFAULT = 4,
   parameter int ACC_W        = 36
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic signed [15:0] S_AXIS_tdata,
   input  logic               S_AXIS_tvalid,
   output logic               S_AXIS_tready,
   input  logic               S_AXIS_tlast,
`ifdef CIC_INTERP_CFG_EN
   input  logic [15:0]        S_AXIS_CONFIG_tdata,
   input  logic               S_AXIS_CONFIG_tvalid,
   output logic               S_AXIS_CONFIG_tready,
`endif
   output logic signed [15:0] M_AXIS_tdata,
   output logic               M_AXIS_tvalid,
   input  logic               M_AXIS_tready,
   output logic               M_AXIS_tlast
);

   typedef enum logic [1:0] {WAIT_I, WAIT_Q, EMIT} state_t;

   // log2 of a legal rate; zero marks an illegal rate value
   function automatic logic [2:0] rate_log2(input logic [7:0] r);
      case (r)
         8'd2:    rate_log2 = 3'd1;
         8'd4:    rate_log2 = 3'd2;
         8'd8:    rate_log2 = 3'd3;
         8'd16:   rate_log2 = 3'd4;
         8'd32:   rate_log2 = 3'd5;
         8'd64:   rate_log2 = 3'd6;
         default: rate_log2 = 3'd0;
      endcase
   endfunction

   localparam logic [2:0] LG_DEFAULT = rate_log2(8'(RATE_DEFAULT));

   state_t                  state_q, state_d;
   logic                    rst_done;
   logic                    s_rdy, cfg_rdy, cfg_vld, cfg_hs, s_hs, m_hs;
   logic [2:0]              cfg_lg, rate_lg;
   logic [3:0]              shamt;
   logic [7:0]              nbeats, beat_q;
   logic                    beat_ch, comb_ok, load, emit_done;
   logic signed [15:0]      samp_i, samp_q;
   logic signed [ACC_W-1:0] samp_ext [2];
   logic signed [ACC_W-1:0] x_d [2], c1_d [2], c2_d [2], c3 [2];
   logic signed [ACC_W-1:0] c1_n [2], c2_n [2], c3_n [2];
   logic signed [ACC_W-1:0] i1 [2], i2 [2], i3 [2];
   logic signed [ACC_W-1:0] integ_in, i1_n, i2_n, i3_n;
   logic                    out_vld, out_last;
   logic signed [15:0]      out_dat;

`ifdef CIC_INTERP_CFG_EN
   logic cfg_unused;
   assign cfg_vld              = S_AXIS_CONFIG_tvalid;
   assign cfg_lg               = rate_log2(S_AXIS_CONFIG_tdata[7:0]);
   assign cfg_unused           = ^S_AXIS_CONFIG_tdata[15:8];
   assign S_AXIS_CONFIG_tready = cfg_rdy;
`else
   assign cfg_vld = 1'b0;
   assign cfg_lg  = 3'd0;
`endif

   assign cfg_hs        = cfg_vld && cfg_rdy;
   assign s_hs          = S_AXIS_tvalid && s_rdy;
   assign m_hs          = out_vld && M_AXIS_tready;
   assign S_AXIS_tready = s_rdy;
   assign M_AXIS_tvalid = out_vld;
   assign M_AXIS_tdata  = out_dat;
   assign M_AXIS_tlast  = out_last;

   // gain of R^2 is removed by a shift of 2*log2(R); a burst is 2R beats
   assign shamt  = {rate_lg, 1'b0};
   assign nbeats = 8'd2 << rate_lg;

   assign samp_ext[0] = {{(ACC_W-16){samp_i[15]}}, samp_i};
   assign samp_ext[1] = {{(ACC_W-16){samp_q[15]}}, samp_q};

   // comb section (low rate): three first differences per channel
   always_comb begin
      for (int ch = 0; ch < 2; ch++) begin
         c1_n[ch] = samp_ext[ch] - x_d[ch];
         c2_n[ch] = c1_n[ch] - c1_d[ch];
         c3_n[ch] = c2_n[ch] - c2_d[ch];
      end
   end

   // integrator section (high rate): only the first pair of a burst sees the comb output, the rest are stuffed zeros
   assign beat_ch   = beat_q[0];
   assign integ_in  = (beat_q[7:1] == 7'd0) ? c3[beat_ch] : '0;
   assign i1_n      = i1[beat_ch] + integ_in;
   assign i2_n      = i2[beat_ch] + i1_n;
   assign i3_n      = i3[beat_ch] + i2_n;
   assign load      = (state_q == EMIT) && comb_ok && (beat_q != nbeats) && (!out_vld || M_AXIS_tready);
   assign emit_done = (state_q == EMIT) && m_hs && (beat_q == nbeats);

   // state register; rst_done keeps the input side closed until the first edge after reset
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= WAIT_I;
         rst_done <= 1'b0;
      end else begin
         state_q  <= state_d;
         rst_done <= 1'b1;
      end
   end

   // next state and handshake readies; a pending config blocks the data input in WAIT_I
   always_comb begin
      state_d = state_q;
      s_rdy   = 1'b0;
      cfg_rdy = 1'b0;
      case (state_q)
         WAIT_I: begin
            cfg_rdy = rst_done;
            s_rdy   = rst_done && !cfg_vld;
            if (S_AXIS_tvalid && s_rdy && !S_AXIS_tlast) state_d = WAIT_Q;
         end
         WAIT_Q: begin
            s_rdy = rst_done;
            if (S_AXIS_tvalid && s_rdy && S_AXIS_tlast) state_d = EMIT;
         end
         EMIT: begin
            if (emit_done) state_d = WAIT_I;
         end
         default: state_d = WAIT_I;
      endcase
   end

   // datapath: sample capture, rate config, comb update, integrator/output stage
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rate_lg  <= LG_DEFAULT;
         samp_i   <= '0;
         samp_q   <= '0;
         comb_ok  <= 1'b0;
         beat_q   <= '0;
         out_vld  <= 1'b0;
         out_last <= 1'b0;
         out_dat  <= '0;
         for (int ch = 0; ch < 2; ch++) begin
            x_d[ch] <= '0; c1_d[ch] <= '0; c2_d[ch] <= '0; c3[ch] <= '0;
            i1[ch]  <= '0; i2[ch]   <= '0; i3[ch]   <= '0;
         end
      end else begin
         if (cfg_hs && (cfg_lg != 3'd0)) begin
            rate_lg <= cfg_lg;
            for (int ch = 0; ch < 2; ch++) begin
               x_d[ch] <= '0; c1_d[ch] <= '0; c2_d[ch] <= '0; c3[ch] <= '0;
               i1[ch]  <= '0; i2[ch]   <= '0; i3[ch]   <= '0;
            end
         end
         // a second I beat in WAIT_Q simply overwrites the held I sample
         if (s_hs && !S_AXIS_tlast) samp_i <= S_AXIS_tdata;
         if (s_hs && S_AXIS_tlast && (state_q == WAIT_Q)) samp_q <= S_AXIS_tdata;
         if ((state_q == EMIT) && !comb_ok) begin
            comb_ok <= 1'b1;
            for (int ch = 0; ch < 2; ch++) begin
               x_d[ch]  <= samp_ext[ch];
               c1_d[ch] <= c1_n[ch];
               c2_d[ch] <= c2_n[ch];
               c3[ch]   <= c3_n[ch];
            end
         end
         if (load) begin
            i1[beat_ch] <= i1_n;
            i2[beat_ch] <= i2_n;
            i3[beat_ch] <= i3_n;
            out_dat     <= 16'(i3_n >>> shamt);
            out_last    <= beat_ch;
            out_vld     <= 1'b1;
            beat_q      <= beat_q + 8'd1;
         end else if (m_hs) begin
            out_vld <= 1'b0;
         end
         if (emit_done) begin
            comb_ok <= 1'b0;
            beat_q  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cic_interpolator.sv
`timescale 1ns/1ps
module tb_cic_interpolator;
   localparam int ACC_W        = 36;
   localparam int RATE_DEFAULT = 4;

   logic               aclk = 1'b0;
   logic               aresetn = 1'b1;
   logic signed [15:0] S_AXIS_tdata = '0;
   logic               S_AXIS_tvalid = 1'b0;
   logic               S_AXIS_tready;
   logic               S_AXIS_tlast = 1'b0;
`ifdef CIC_INTERP_CFG_EN
   logic [15:0]        S_AXIS_CONFIG_tdata = '0;
   logic               S_AXIS_CONFIG_tvalid = 1'b0;
   logic               S_AXIS_CONFIG_tready;
`endif
   logic signed [15:0] M_AXIS_tdata;
   logic               M_AXIS_tvalid;
   logic               M_AXIS_tready = 1'b1;
   logic               M_AXIS_tlast;

   always #5 aclk = ~aclk;

   cic_interpolator #(.RATE_DEFAULT(RATE_DEFAULT), .ACC_W(ACC_W)) dut (
      .aclk                 (aclk),
      .aresetn              (aresetn),
      .S_AXIS_tdata         (S_AXIS_tdata),
      .S_AXIS_tvalid        (S_AXIS_tvalid),
      .S_AXIS_tready        (S_AXIS_tready),
      .S_AXIS_tlast         (S_AXIS_tlast),
`ifdef CIC_INTERP_CFG_EN
      .S_AXIS_CONFIG_tdata  (S_AXIS_CONFIG_tdata),
      .S_AXIS_CONFIG_tvalid (S_AXIS_CONFIG_tvalid),
      .S_AXIS_CONFIG_tready (S_AXIS_CONFIG_tready),
`endif
      .M_AXIS_tdata         (M_AXIS_tdata),
      .M_AXIS_tvalid        (M_AXIS_tvalid),
      .M_AXIS_tready        (M_AXIS_tready),
      .M_AXIS_tlast         (M_AXIS_tlast)
   );

   typedef struct packed {
      logic [15:0] dat;
      logic        last;
   } exp_t;

   typedef struct packed {
      logic signed [15:0] in_i;
      logic signed [15:0] in_q;
      logic [3:0][15:0]   exp_i;
      logic [3:0][15:0]   exp_q;
   } vec_t;

   exp_t   sb [$];
   vec_t   vt [3];
   int     n_pass = 0;
   int     n_total = 0;
   int     beat_cnt = 0;
   int     last_i = 0;
   int     last_q = 0;
   bit     stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   // reference CIC state, per channel
   longint m_xd [2], m_c1d [2], m_c2d [2], m_i1 [2], m_i2 [2], m_i3 [2];
   int     m_rate = RATE_DEFAULT;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic vec_t mk_vec(input int ii, input int iq, input int e0, input int e1,
                                   input int e2, input int e3);
      vec_t v;
      v.in_i = 16'(ii);
      v.in_q = 16'(iq);
      v.exp_i[0] = 16'(e0); v.exp_i[1] = 16'(e1); v.exp_i[2] = 16'(e2); v.exp_i[3] = 16'(e3);
      v.exp_q = '0;
      return v;
   endfunction

   function automatic void model_clear();
      for (int ch = 0; ch < 2; ch++) begin
         m_xd[ch] = 0; m_c1d[ch] = 0; m_c2d[ch] = 0;
         m_i1[ch] = 0; m_i2[ch] = 0; m_i3[ch] = 0;
      end
   endfunction

   // one input pair through the reference filter; optionally queues the 2R expected beats
   function automatic void model_pair(input int si, input int sq, input bit push);
      longint x [2];
      longint c1, c2, u;
      longint c3 [2];
      exp_t   e;
      x[0] = si;
      x[1] = sq;
      for (int ch = 0; ch < 2; ch++) begin
         c1 = x[ch] - m_xd[ch];
         c2 = c1 - m_c1d[ch];
         c3[ch] = c2 - m_c2d[ch];
         m_xd[ch] = x[ch]; m_c1d[ch] = c1; m_c2d[ch] = c2;
      end
      for (int p = 0; p < m_rate; p++) begin
         for (int ch = 0; ch < 2; ch++) begin
            u = (p == 0) ? c3[ch] : 0;
            m_i1[ch] += u;
            m_i2[ch] += m_i1[ch];
            m_i3[ch] += m_i2[ch];
            e.dat  = 16'(m_i3[ch] >>> (2 * $clog2(m_rate)));
            e.last = (ch == 1);
            if (push) sb.push_back(e);
         end
      end
   endfunction

   // output monitor: scoreboard compare on each handshake, stability check while stalled
   bit          hold_chk = 1'b0;
   logic [15:0] hold_dat;
   logic        hold_last;
   always @(negedge aclk) begin
      exp_t e;
      if (!aresetn) begin
         hold_chk = 1'b0;
      end else begin
         if (hold_chk && M_AXIS_tvalid) begin
            check(M_AXIS_tdata == hold_dat, "stall_hold_dat", int'(M_AXIS_tdata), int'($signed(hold_dat)));
            check(M_AXIS_tlast == hold_last, "stall_hold_last", int'(M_AXIS_tlast), int'(hold_last));
         end
         hold_chk  = M_AXIS_tvalid && !M_AXIS_tready;
         hold_dat  = M_AXIS_tdata;
         hold_last = M_AXIS_tlast;
         if (M_AXIS_tvalid && M_AXIS_tready) begin
            beat_cnt++;
            if (M_AXIS_tlast) last_q = int'(M_AXIS_tdata);
            else              last_i = int'(M_AXIS_tdata);
            if (sb.size() == 0) begin
               check(1'b0, "unexpected_beat", int'(M_AXIS_tdata), 0);
            end else begin
               e = sb.pop_front();
               check(M_AXIS_tdata == e.dat, "out_dat", int'(M_AXIS_tdata), int'($signed(e.dat)));
               check(M_AXIS_tlast == e.last, "out_last", int'(M_AXIS_tlast), int'(e.last));
            end
         end
      end
   end

   task automatic send_beat(input int d, input bit last);
      int n = 0;
      @(posedge aclk); #1;
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 16'(d);
      S_AXIS_tlast  = last;
      @(negedge aclk);
      while (!S_AXIS_tready && n < 2000) begin
         @(negedge aclk);
         n++;
      end
      check(S_AXIS_tready, "s_handshake", int'(S_AXIS_tready), 1);
      @(posedge aclk); #1;
      S_AXIS_tvalid = 1'b0;
      S_AXIS_tlast  = 1'b0;
   endtask

   task automatic send_pair(input int si, input int sq);
      model_pair(si, sq, 1'b1);
      send_beat(si, 1'b0);
      send_beat(sq, 1'b1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge aclk);
         n++;
      end
      check(sb.size() == 0, "drain_left", sb.size(), 0);
      repeat (3) @(posedge aclk);
   endtask

   task automatic send_cfg(input int val);
`ifdef CIC_INTERP_CFG_EN
      int n = 0;
      @(posedge aclk); #1;
      S_AXIS_CONFIG_tvalid = 1'b1;
      S_AXIS_CONFIG_tdata  = 16'(val);
      @(negedge aclk);
      while (!S_AXIS_CONFIG_tready && n < 2000) begin
         @(negedge aclk);
         n++;
      end
      check(S_AXIS_CONFIG_tready, "cfg_handshake", int'(S_AXIS_CONFIG_tready), 1);
      check(!S_AXIS_tready, "cfg_priority_s_tready", int'(S_AXIS_tready), 0);
      @(posedge aclk); #1;
      S_AXIS_CONFIG_tvalid = 1'b0;
      if (val == 2 || val == 4 || val == 8 || val == 16 || val == 32 || val == 64) begin
         m_rate = val;
         model_clear();
      end
`else
      if (val < 0) m_rate = RATE_DEFAULT;
`endif
   endtask

   task automatic check_reset_outputs();
      check(!M_AXIS_tvalid, "rst_m_tvalid", int'(M_AXIS_tvalid), 0);
      check(!M_AXIS_tlast, "rst_m_tlast", int'(M_AXIS_tlast), 0);
      check(M_AXIS_tdata == 16'sd0, "rst_m_tdata", int'(M_AXIS_tdata), 0);
      check(!S_AXIS_tready, "rst_s_tready", int'(S_AXIS_tready), 0);
`ifdef CIC_INTERP_CFG_EN
      check(!S_AXIS_CONFIG_tready, "rst_cfg_tready", int'(S_AXIS_CONFIG_tready), 0);
`endif
   endtask

   task automatic release_reset();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
      #1;
      check(!S_AXIS_tready, "s_tready_before_edge", int'(S_AXIS_tready), 0);
      @(posedge aclk); #1;
      check(S_AXIS_tready, "s_tready_after_edge", int'(S_AXIS_tready), 1);
   endtask

   // R=4 impulse response from the table, first-beat latency, then flush to a clean state
   task automatic run_table();
      exp_t e;
      int   n;
      for (int r = 0; r < 3; r++) begin
         model_pair(vt[r].in_i, vt[r].in_q, 1'b0);
         for (int p = 0; p < 4; p++) begin
            e.dat = vt[r].exp_i[p]; e.last = 1'b0; sb.push_back(e);
            e.dat = vt[r].exp_q[p]; e.last = 1'b1; sb.push_back(e);
         end
         send_beat(vt[r].in_i, 1'b0);
         send_beat(vt[r].in_q, 1'b1);
         if (r == 0) begin
            n = 0;
            while (!M_AXIS_tvalid && n < 20) begin
               @(posedge aclk); #1;
               n++;
            end
            check(n == 2, "first_beat_latency", n, 2);
         end
      end
      send_pair(0, 0);
      send_pair(0, 0);
      drain(500);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vt[0] = mk_vec(256, 0,  16,  48,  96, 160);
      vt[1] = mk_vec(0,   0, 192, 192, 160,  96);
      vt[2] = mk_vec(0,   0,  48,  16,   0,   0);
      model_clear();

      // reset state
      #2;
      aresetn = 1'b0;
      #1;
      check_reset_outputs();
      release_reset();

      // impulse at R=4, then an illegal config that must change nothing
      send_cfg(4);
      run_table();
      send_cfg(5);
      run_table();

      // leading orphan Q dropped; second of two I beats wins
      model_pair(256, -300, 1'b1);
      send_beat(777, 1'b1);
      send_beat(500, 1'b0);
      send_beat(256, 1'b0);
      send_beat(-300, 1'b1);
      drain(500);

      // output backpressure 1,0,0,1 during a burst at R=8
      send_cfg(8);
      beat_cnt = 0;
      send_pair(1234, -567);
      for (int k = 0; sb.size() != 0 && k < 1000; k++) begin
         @(posedge aclk); #1;
         M_AXIS_tready = stall_pat[k % 4];
      end
      M_AXIS_tready = 1'b1;
      drain(50);
      check(beat_cnt == 2 * m_rate, "stall_beat_count", beat_cnt, 2 * m_rate);

      // constant input at R=64 settles to unity DC gain
      send_cfg(64);
      for (int p = 0; p < 5; p++) send_pair(1000, -1000);
      drain(2000);
      check(last_i == 1000, "dc_gain_i", last_i, 1000);
      check(last_q == -1000, "dc_gain_q", last_q, -1000);

      // reset in the middle of an R=8 burst
      send_cfg(8);
      send_pair(256, 0);
      n = 0;
      while (!M_AXIS_tvalid && n < 20) begin
         @(posedge aclk); #1;
         n++;
      end
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      #1;
      check_reset_outputs();
      sb.delete();
      m_rate = RATE_DEFAULT;
      model_clear();
      release_reset();
      run_table();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter RATE_DEFAULT, default 4, giving the interpolation rate R after reset; legal values 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have parameter ACC_W, default 36, giving the internal comb and integrator register width.
REQ-003 SHALL have these ports; there is one clock, and reset is asynchronous and active-low:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- S_AXIS_tdata  in  16  signed input sample (I, then Q)
- S_AXIS_tvalid  in  1  input beat valid
- S_AXIS_tready  out  1  block accepts an input beat
- S_AXIS_tlast  in  1  marks the Q beat of an I/Q pair
- S_AXIS_CONFIG_tdata  in  16  [7:0] = R
- S_AXIS_CONFIG_tvalid  in  1  config valid
- S_AXIS_CONFIG_tready  out  1  config accepted
- M_AXIS_tdata  out  16  signed output sample
- M_AXIS_tvalid  out  1  output beat valid
- M_AXIS_tready  in  1  downstream accepts the beat
- M_AXIS_tlast  out  1  marks the Q beat of an output pair

Function
REQ-004 SHALL be a 3-stage CIC interpolator, comb section then zero-stuff then integrator section, with I and Q time-multiplexed and each channel keeping independent state.
REQ-005 SHALL have states WAIT_I, WAIT_Q and EMIT.
- WAIT_I: a beat with tlast=1 is dropped and the state stays WAIT_I.
- WAIT_Q: a beat with tlast=0 replaces the held I sample and the state stays WAIT_Q (resync).
- WAIT_Q: a beat with tlast=1 moves the state to EMIT.
REQ-006 SHALL drive S_AXIS_tready=1 in WAIT_I and WAIT_Q, and 0 in EMIT.
REQ-007 In EMIT the block SHALL output R pairs (I beat with tlast=0, then Q beat with tlast=1).
- The first pair is formed from the comb outputs.
- Each later pair is formed from zero inputs into the integrators.
- After the R-th Q beat the state returns to WAIT_I.
REQ-008 The first output I beat SHALL have M_AXIS_tvalid=1 exactly 2 cycles after the Q input handshake.
REQ-009 With M_AXIS_tready held at 1, the output SHALL produce one beat per cycle.
REQ-010 While M_AXIS_tvalid=1 and M_AXIS_tready=0, M_AXIS_tdata and M_AXIS_tlast SHALL hold stable and integrator state SHALL not advance.
REQ-011 Internal arithmetic SHALL be ACC_W-bit two's complement, and modular wrap SHALL be permitted in intermediate registers.
REQ-012 Output SHALL be the integrator result arithmetic-shifted right by 2*log2(R), truncated, and taken as the low 16 bits, giving DC gain exactly 1.
REQ-013 S_AXIS_CONFIG_tready SHALL be 1 only in WAIT_I; config handshakes at any other time are not possible.
REQ-014 An accepted config with tdata[7:0] in {2,4,8,16,32,64} SHALL set R on the next cycle and clear all comb and integrator state.
REQ-015 A config handshake with any other tdata[7:0] value SHALL complete the handshake and leave R and filter state unchanged.
REQ-016 If input tvalid and config tvalid are both 1 in WAIT_I, the config SHALL take priority and the input beat SHALL not be accepted that cycle.

Reset
REQ-017 While aresetn=0 the block SHALL immediately hold M_AXIS_tvalid=0, M_AXIS_tlast=0, M_AXIS_tdata=0, S_AXIS_tready=0 and S_AXIS_CONFIG_tready=0.
REQ-018 Reset SHALL clear all filter state, set R=RATE_DEFAULT and set state to WAIT_I.
REQ-019 Reset asserted mid-EMIT SHALL abandon the remaining beats.
REQ-020 On the first aclk edge after aresetn=1, S_AXIS_tready SHALL become 1.

Configuration
REQ-021 With macro CIC_INTERP_CFG_EN defined, the S_AXIS_CONFIG_* ports and REQ-013 through REQ-016 SHALL be present.
REQ-022 Without CIC_INTERP_CFG_EN, the S_AXIS_CONFIG_* ports SHALL be absent and R SHALL be fixed at RATE_DEFAULT.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then R=4 configured; input pairs (256,0), then (0,0) x2, with M_AXIS_tready=1 -> I outputs 16,48,96,160,192,192,160,96,48,16,0,0; all Q outputs 0.
- Constant pair (1000,-1000) at R=64 -> after settling, every I output is 1000 and every Q output is -1000; tlast=1 on every Q beat.
- M_AXIS_tready toggled 1,0,0,1 during EMIT -> no beat lost or duplicated; data held while stalled; exactly 2R beats per input pair.
- Config value 5 sent while in WAIT_I -> handshake completes; R unchanged; output identical to the prior run.
- aresetn pulsed low mid-EMIT at R=8 -> M_AXIS_tvalid drops within the same cycle; R returns to RATE_DEFAULT; next impulse matches the clean R=4 response.
- Two consecutive I beats (tlast=0), then Q -> only the second I is used; a leading orphan Q beat is dropped.
